// File: rtl/cpu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : cpu_pkg                                                |
// | Description : Shared CPU constants: fetch FSM encoding, reset PC     |
// |               default and the PC increment.                          |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package cpu_pkg;

  // Fetch FSM states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] PC_INC           = 32'd4;

endpackage
`default_nettype wire

// File: rtl/next_pc_sel.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : next_pc_sel                                            |
// | Description : Combinational next-PC selection. Priority is           |
// |               jr > jump > branch > sequential. All adds wrap mod 2^32.|
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module next_pc_sel
  import cpu_pkg::*;
(
  input  logic [31:0] pc_i,
  input  logic        pcsrc_i,
  input  logic [31:0] imm_ext_i,
  input  logic        jump_i,
  input  logic [25:0] jtarget_i,
  input  logic        jr_i,
  input  logic [31:0] jr_addr_i,
  output logic [31:0] pc_plus4_o,
  output logic [31:0] next_pc_o
);

  logic [31:0] plus4;
  logic [31:0] br_target;
  logic [31:0] j_target;
  logic [31:0] jr_target;

  assign plus4      = pc_i + PC_INC;
  // Immediate is a word offset; shifting out its top bits is the intended wrap
  assign br_target  = plus4 + (imm_ext_i << 2);
  assign j_target   = {plus4[31:28], jtarget_i, 2'b00};
  // Masking keeps the full register in use while forcing word alignment
  assign jr_target  = jr_addr_i & 32'hFFFF_FFFC;
  assign pc_plus4_o = plus4;

  // Fixed-priority target mux
  always_comb begin
    next_pc_o = plus4;
    if (jr_i) begin
      next_pc_o = jr_target;
    end else if (jump_i) begin
      next_pc_o = j_target;
    end else if (pcsrc_i) begin
      next_pc_o = br_target;
    end
  end

endmodule
`default_nettype wire

// File: rtl/pc_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : pc_unit                                                |
// | Description : Program counter register and fetch FSM                 |
// |               (IDLE -> FETCH -> HALT). The PC advances only on an    |
// |               accept: FETCH with imem_ready high and stall low.      |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module pc_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pcsrc,
  input  logic [31:0] imm_ext,
  input  logic        jump,
  input  logic [25:0] jtarget,
  input  logic        jr,
  input  logic [31:0] jr_addr,
  input  logic        stall,
  input  logic        halt,
  input  logic        imem_ready,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        imem_req,
  output logic        commit,
  output logic        halted
);

  state_t      state_q;
  logic [31:0] pc_q;
  logic [31:0] pc_d;
  logic        imem_req_q;
  logic        commit_q;
  logic        halted_q;
  logic        accept;

  // Control inputs are only ever consumed through an accept
  assign accept = (state_q == ST_FETCH) && imem_ready && !stall;

  next_pc_sel u_next_pc_sel (
    .pc_i       (pc_q),
    .pcsrc_i    (pcsrc),
    .imm_ext_i  (imm_ext),
    .jump_i     (jump),
    .jtarget_i  (jtarget),
    .jr_i       (jr),
    .jr_addr_i  (jr_addr),
    .pc_plus4_o (pc_plus4),
    .next_pc_o  (pc_d)
  );

  // Fetch FSM with PC register and registered status outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      pc_q       <= RESET_PC;
      imem_req_q <= 1'b0;
      commit_q   <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      commit_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          state_q    <= ST_FETCH;
          imem_req_q <= 1'b1;
        end
        ST_FETCH: begin
          if (accept) begin
            if (halt) begin
              // Halting instruction retires without moving the PC
              state_q    <= ST_HALT;
              imem_req_q <= 1'b0;
              halted_q   <= 1'b1;
            end else begin
              pc_q     <= pc_d;
              commit_q <= 1'b1;
            end
          end
        end
        ST_HALT: begin
          imem_req_q <= 1'b0;
          halted_q   <= 1'b1;
        end
        default: begin
          state_q    <= ST_IDLE;
          imem_req_q <= 1'b0;
          halted_q   <= 1'b0;
        end
      endcase
    end
  end

  assign pc       = pc_q;
  assign imem_req = imem_req_q;
  assign commit   = commit_q;
  assign halted   = halted_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_pc_unit                                             |
// | Description : Self-checking bench for pc_unit: next-PC vector table  |
// |               plus hand sequences for fetch, stall, halt and reset.  |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_pc_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk;
  logic        reset;
  logic        pcsrc;
  logic [31:0] imm_ext;
  logic        jump;
  logic [25:0] jtarget;
  logic        jr;
  logic [31:0] jr_addr;
  logic        stall;
  logic        halt;
  logic        imem_ready;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        imem_req;
  logic        commit;
  logic        halted;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string       name;
    logic [31:0] start;
    logic        pcsrc;
    logic [31:0] imm;
    logic        jump;
    logic [25:0] jt;
    logic        jr;
    logic [31:0] jra;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[12];

  pc_unit #(.RESET_PC(RST_PC)) dut (
    .clk        (clk),
    .reset      (reset),
    .pcsrc      (pcsrc),
    .imm_ext    (imm_ext),
    .jump       (jump),
    .jtarget    (jtarget),
    .jr         (jr),
    .jr_addr    (jr_addr),
    .stall      (stall),
    .halt       (halt),
    .imem_ready (imem_ready),
    .pc         (pc),
    .pc_plus4   (pc_plus4),
    .imem_req   (imem_req),
    .commit     (commit),
    .halted     (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Global time limit so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ctrl();
    pcsrc      = 1'b0;
    imm_ext    = 32'h0;
    jump       = 1'b0;
    jtarget    = 26'h0;
    jr         = 1'b0;
    jr_addr    = 32'h0;
    stall      = 1'b0;
    halt       = 1'b0;
    imem_ready = 1'b1;
  endtask

  // Load an arbitrary PC through a jr accept
  task automatic set_pc(input logic [31:0] addr);
    clear_ctrl();
    jr      = 1'b1;
    jr_addr = addr;
    step();
    check32("set_pc", pc, addr);
    clear_ctrl();
  endtask

  initial begin
    vecs[0]  = '{"seq",          32'h0000_0100, 1'b0, 32'h0,         1'b0, 26'h0,       1'b0, 32'h0,         32'h0000_0104};
    vecs[1]  = '{"branch_back",  32'h0000_0040, 1'b1, 32'hFFFF_FFFE, 1'b0, 26'h0,       1'b0, 32'h0,         32'h0000_003C};
    vecs[2]  = '{"prio_jr",      32'h1000_0000, 1'b0, 32'h0,         1'b1, 26'h10,      1'b1, 32'h0000_0123, 32'h0000_0120};
    vecs[3]  = '{"prio_jump",    32'h1000_0000, 1'b1, 32'h5,         1'b1, 26'h10,      1'b0, 32'h0,         32'h1000_0040};
    vecs[4]  = '{"jump_max",     32'hF000_0000, 1'b0, 32'h0,         1'b1, 26'h3FF_FFFF,1'b0, 32'h0,         32'hFFFF_FFFC};
    vecs[5]  = '{"plus4_wrap",   32'hFFFF_FFFC, 1'b0, 32'h0,         1'b0, 26'h0,       1'b0, 32'h0,         32'h0000_0000};
    vecs[6]  = '{"jump_wrap",    32'hFFFF_FFFC, 1'b0, 32'h0,         1'b1, 26'h1,       1'b0, 32'h0,         32'h0000_0004};
    vecs[7]  = '{"branch_wrap",  32'hFFFF_FFF8, 1'b1, 32'h4,         1'b0, 26'h0,       1'b0, 32'h0,         32'h0000_000C};
    vecs[8]  = '{"branch_fwd",   32'h0000_0200, 1'b1, 32'h10,        1'b0, 26'h0,       1'b0, 32'h0,         32'h0000_0244};
    vecs[9]  = '{"jr_align",     32'h0000_0300, 1'b1, 32'h7,         1'b1, 26'h5,       1'b1, 32'h8765_4323, 32'h8765_4320};
    vecs[10] = '{"no_branch",    32'h0000_0300, 1'b0, 32'h40,        1'b0, 26'h0,       1'b0, 32'h0,         32'h0000_0304};
    vecs[11] = '{"branch_big",   32'h0000_0000, 1'b1, 32'h1FFF_FFFF, 1'b0, 26'h0,       1'b0, 32'h0,         32'h8000_0000};

    // Reset state
    clear_ctrl();
    reset = 1'b1;
    #12;
    check32("rst_pc", pc, RST_PC);
    check1("rst_imem_req", imem_req, 1'b0);
    check1("rst_commit", commit, 1'b0);
    check1("rst_halted", halted, 1'b0);

    // Sequential fetch: IDLE -> FETCH, then 0,4,8,12
    @(negedge clk);
    reset = 1'b0;
    step();
    check1("fetch_req", imem_req, 1'b1);
    check32("fetch_pc0", pc, 32'h0);
    check1("fetch_commit0", commit, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      step();
      check32("seq_pc", pc, 32'(i * 4));
      check1("seq_commit", commit, 1'b1);
    end

    // Wait for memory with control inputs that must be ignored
    imem_ready = 1'b0;
    pcsrc      = 1'b1;
    jump       = 1'b1;
    jtarget    = 26'h3;
    for (int i = 0; i < 2; i++) begin
      step();
      check32("wait_pc", pc, 32'hC);
      check1("wait_commit", commit, 1'b0);
      check1("wait_req", imem_req, 1'b1);
    end
    // Ready but stalled, halt ignored
    imem_ready = 1'b1;
    stall      = 1'b1;
    halt       = 1'b1;
    step();
    check32("stall_pc", pc, 32'hC);
    check1("stall_commit", commit, 1'b0);
    check1("stall_req", imem_req, 1'b1);
    check1("stall_halted", halted, 1'b0);
    clear_ctrl();
    step();
    check32("unstall_pc", pc, 32'h10);
    check1("unstall_commit", commit, 1'b1);

    // Next-PC vector table
    for (int i = 0; i < 12; i++) begin
      set_pc(vecs[i].start);
      check32({vecs[i].name, "_plus4"}, pc_plus4, vecs[i].start + 32'd4);
      pcsrc   = vecs[i].pcsrc;
      imm_ext = vecs[i].imm;
      jump    = vecs[i].jump;
      jtarget = vecs[i].jt;
      jr      = vecs[i].jr;
      jr_addr = vecs[i].jra;
      step();
      check32(vecs[i].name, pc, vecs[i].exp);
      check1({vecs[i].name, "_commit"}, commit, 1'b1);
      clear_ctrl();
    end

    // Halt at pc 0x8, sticky against later control inputs
    set_pc(32'h8);
    halt = 1'b1;
    step();
    check1("halt_halted", halted, 1'b1);
    check32("halt_pc", pc, 32'h8);
    check1("halt_commit", commit, 1'b0);
    check1("halt_req", imem_req, 1'b0);
    halt    = 1'b0;
    jr      = 1'b1;
    jr_addr = 32'h100;
    for (int i = 0; i < 2; i++) begin
      step();
      check1("sticky_halted", halted, 1'b1);
      check32("sticky_pc", pc, 32'h8);
      check1("sticky_req", imem_req, 1'b0);
    end

    // Asynchronous reset mid-cycle leaves HALT
    #3;
    reset = 1'b1;
    #1;
    check32("areset_pc", pc, RST_PC);
    check1("areset_halted", halted, 1'b0);
    check1("areset_req", imem_req, 1'b0);
    clear_ctrl();
    @(negedge clk);
    reset = 1'b0;
    step();
    check1("rerun_req", imem_req, 1'b1);
    check32("rerun_pc", pc, RST_PC);

    // Reset abandons a pending accept
    set_pc(32'h500);
    jump    = 1'b1;
    jtarget = 26'h40;
    #2;
    reset = 1'b1;
    #1;
    check32("abandon_pc", pc, RST_PC);
    check1("abandon_commit", commit, 1'b0);
    check1("abandon_req", imem_req, 1'b0);
    step();
    check32("abandon_hold_pc", pc, RST_PC);
    check1("abandon_hold_commit", commit, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    step();
    check32("idle_ignore_pc", pc, RST_PC);
    check1("idle_ignore_commit", commit, 1'b0);
    check1("idle_ignore_req", imem_req, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
